// File: rtl/decoder_select_sched.sv
// Round-robin scheduler for one shared 8-way one-hot select resource.
// A grant is held until done, requester withdrawal or hold timeout, then one
// mandatory idle (GAP) cycle separates consecutive grants.
module decoder_select_sched #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_vld,
  output logic [2:0] gnt_idx,
  output logic [7:0] dout,
  output logic       timeout
);

  localparam int unsigned HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  // Counter value on the last permitted BUSY cycle.
  localparam logic [HCW-1:0] HoldLast = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;

  typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

  state_e         state_q, state_d;
  logic           gnt_vld_q, gnt_vld_d;
  logic [2:0]     gnt_idx_q, gnt_idx_d;
  logic [7:0]     dout_q, dout_d;
  logic           timeout_q, timeout_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]     ptr_q, ptr_d;

  logic [2:0] sel;
  logic       sel_vld;
  logic [2:0] cand;
  logic       rel_done, rel_wd, rel_lim, rel_any;

  // Round-robin pick: first set request searching from ptr+1 upward, wrapping.
  always_comb begin
    sel     = ptr_q;
    sel_vld = 1'b0;
    cand    = ptr_q;
    for (int i = 1; i <= 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!sel_vld && req[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  assign rel_done = done;
  assign rel_wd   = ~req[gnt_idx_q];
  assign rel_lim  = (MAX_HOLD != 0) && (hold_cnt_q == HoldLast);
  assign rel_any  = rel_done | rel_wd | rel_lim;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_vld_q  <= 1'b0;
      gnt_idx_q  <= 3'd0;
      dout_q     <= 8'h00;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
      ptr_q      <= 3'd7;
    end else begin
      state_q    <= state_d;
      gnt_vld_q  <= gnt_vld_d;
      gnt_idx_q  <= gnt_idx_d;
      dout_q     <= dout_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold in BUSY until release, one GAP cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en && sel_vld) state_d = StBusy;
      StBusy:  if (rel_any) state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output/datapath next values; gnt_idx and ptr retain outside a new grant.
  always_comb begin
    gnt_vld_d  = gnt_vld_q;
    gnt_idx_d  = gnt_idx_q;
    dout_d     = dout_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      StIdle: begin
        gnt_vld_d = 1'b0;
        dout_d    = 8'h00;
        if (en && sel_vld) begin
          gnt_vld_d  = 1'b1;
          gnt_idx_d  = sel;
          dout_d     = 8'h01 << sel;
          ptr_d      = sel;
          hold_cnt_d = '0;
        end
      end
      StBusy: begin
        if (rel_any) begin
          gnt_vld_d = 1'b0;
          dout_d    = 8'h00;
          // Flag timeout only when the limit alone forced the release.
          timeout_d = rel_lim & ~rel_done & ~rel_wd;
        end else begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      StGap: begin
        gnt_vld_d = 1'b0;
        dout_d    = 8'h00;
      end
      default: begin
        gnt_vld_d = 1'b0;
        dout_d    = 8'h00;
      end
    endcase
  end

  assign gnt_vld = gnt_vld_q;
  assign gnt_idx = gnt_idx_q;
  assign dout    = dout_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_decoder_select_sched.sv
// Bench for decoder_select_sched: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_decoder_select_sched;

  localparam int MaxHold = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       gnt_vld;
  logic [2:0] gnt_idx;
  logic [7:0] dout;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  decoder_select_sched #(.MAX_HOLD(MaxHold)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx),
    .dout    (dout),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = waiting for arbitration, 1 = grant held, 2 = break cycle
  int m_phase = 0;
  int m_ptr   = 7;
  int m_idx   = 0;
  int m_held  = 0;  // cycles the current grant has been visible
  bit m_vld   = 0;
  bit m_to    = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_ptr = 7; m_idx = 0; m_held = 0; m_vld = 0; m_to = 0;
      end else begin
        case (m_phase)
          0: begin
            m_to = 0;
            if (en && req != 8'h00) begin
              for (int k = 1; k <= 8; k++) begin
                if (m_phase == 0 && req[(m_ptr + k) % 8]) begin
                  m_idx = (m_ptr + k) % 8;
                  m_ptr = m_idx;
                  m_vld = 1; m_held = 1; m_phase = 1;
                end
              end
            end
          end
          1: begin
            bit lim;
            lim = (MaxHold != 0) && (m_held == MaxHold);
            if (done || !req[m_idx] || lim) begin
              m_to = lim && !done && req[m_idx];
              m_vld = 0; m_phase = 2;
            end else begin
              m_held++;
            end
          end
          default: begin
            m_to = 0; m_phase = 0;
          end
        endcase
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic [7:0] m_dout;
        m_dout = m_vld ? (8'h01 << m_idx) : 8'h00;
        check("model gnt_vld", gnt_vld, m_vld);
        check("model gnt_idx", gnt_idx, m_idx);
        check("model dout", dout, m_dout);
        check("model timeout", timeout, m_to);
        check("dout onehot", ($countones(dout) <= 1), 1);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (!gnt_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " grant timely"}, gnt_vld, 1);
  endtask

  initial begin
    int cnt;
    // Reset values
    tick(2);
    check("rst gnt_vld", gnt_vld, 0);
    check("rst gnt_idx", gnt_idx, 0);
    check("rst dout", dout, 8'h00);
    check("rst timeout", timeout, 0);
    rst_n = 1'b1;

    // 1: single request, done release
    req = 8'h01; en = 1'b1;
    tick(1);
    check("t1 vld", gnt_vld, 1);
    check("t1 idx", gnt_idx, 0);
    check("t1 dout", dout, 8'h01);
    done = 1'b1;
    tick(1);
    check("t1 gap dout", dout, 8'h00);
    done = 1'b0; req = 8'h00;
    tick(2);

    // 2: all requesting, round-robin order from reset
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1; req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      wait_grant("t2");
      check("t2 order", gnt_idx, k % 8);
      check("t2 dout", dout, 8'h01 << (k % 8));
      done = 1'b1;
      tick(1);
      check("t2 gap", dout, 8'h00);
      done = 1'b0;
    end
    req = 8'h00;
    tick(3);

    // 3: hold timeout
    req = 8'h08;
    wait_grant("t3");
    cnt = 0;
    while (dout === 8'h08 && cnt < 40) begin
      cnt++;
      tick(1);
    end
    check("t3 hold cycles", cnt, 16);
    check("t3 timeout pulse", timeout, 1);
    check("t3 gap dout", dout, 8'h00);
    tick(1);
    check("t3 timeout cleared", timeout, 0);
    tick(1);
    check("t3 regrant vld", gnt_vld, 1);
    check("t3 regrant idx", gnt_idx, 3);

    // 4: wrap past 6,7 after last grant 5
    req = 8'h00;
    tick(3);
    req = 8'h20;
    wait_grant("t4a");
    check("t4 first idx", gnt_idx, 5);
    done = 1'b1; tick(1); done = 1'b0; req = 8'h21;
    wait_grant("t4b");
    check("t4 wrap idx", gnt_idx, 0);
    done = 1'b1; tick(1); done = 1'b0;
    wait_grant("t4c");
    check("t4 back idx", gnt_idx, 5);
    done = 1'b1; tick(1); done = 1'b0; req = 8'h00;
    tick(2);

    // 5a: withdrawal release
    req = 8'h04;
    wait_grant("t5a");
    check("t5 idx", gnt_idx, 2);
    tick(2);
    req = 8'h00;
    tick(1);
    check("t5 wd vld", gnt_vld, 0);
    check("t5 wd timeout", timeout, 0);
    tick(2);
    // 5b: done coincident with limit
    req = 8'h04;
    wait_grant("t5b");
    tick(15);
    check("t5 held at limit", dout, 8'h04);
    done = 1'b1;
    tick(1);
    check("t5 lim+done dout", dout, 8'h00);
    check("t5 lim+done timeout", timeout, 0);
    done = 1'b0; req = 8'h00;
    tick(2);

    // 6: enable gating, async reset mid-grant
    en = 1'b0; req = 8'h10;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("t6 gated", gnt_vld, 0);
    end
    en = 1'b1;
    tick(1);
    check("t6 vld", gnt_vld, 1);
    check("t6 idx", gnt_idx, 4);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async dout", dout, 8'h00);
    check("t6 async vld", gnt_vld, 0);
    check("t6 async idx", gnt_idx, 0);
    @(negedge clk);
    req = 8'hFF; rst_n = 1'b1;
    tick(1);
    check("t6 post-reset idx", gnt_idx, 0);
    check("t6 post-reset vld", gnt_vld, 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      if ($urandom % 4 == 0) req = 8'($urandom);
      done = ($urandom % ((c < 1500) ? 5 : 40)) == 0;
      en   = ($urandom % 8) != 0;
      if ($urandom % 700 == 0) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
    end
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_select_sched.md
Name: decoder_select_sched

Overview:
Round-robin scheduler that shares one 8-way select resource among 8 requesters. The resource is a 3-to-8 one-hot decode of a grant index. The block arbitrates, drives a registered 3-bit index and its one-hot decode, holds the grant until release, and enforces a hold timeout. It sits in front of decoder-driven chip-select and enable fan-out paths.

Parameters:
MAX_HOLD, 16, maximum cycles a grant may stay in BUSY before forced release; 0 disables the timeout
HCW, $clog2(MAX_HOLD+1) (min 1), hold counter width; derived, not overridden

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  global enable; new grants only while high
req  input  8  request vector, bit i = requester i
done  input  1  current grantee finished; sampled only in BUSY
gnt_vld  output  1  grant active
gnt_idx  output  3  index of current/last grantee
dout  output  8  one-hot select = decode of gnt_idx when gnt_vld, else 0
timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. All outputs are registered.
- Reset values: state=IDLE, gnt_vld=0, gnt_idx=0, dout=8'h00, timeout=0, hold_cnt=0, last pointer ptr=7 (index 0 has top priority after reset).
- FSM states:
  - IDLE: if en=1 and req!=0, select the first set bit searching ptr+1, ptr+2, ... mod 8. At the next edge: gnt_idx=sel, gnt_vld=1, dout=1<<sel, ptr=sel, hold_cnt=0, state=BUSY. Latency from req sampled to dout valid is 1 cycle. Otherwise stay in IDLE with outputs 0 (gnt_idx retains its last value).
  - BUSY: grant held. hold_cnt increments each cycle. Release at the edge where any of these holds:
    - done=1;
    - req[gnt_idx]=0 (requester withdrew);
    - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
    On release: next state=GAP, gnt_vld=0, dout=0. timeout=1 for exactly one cycle (the GAP cycle) only when release was caused by the counter alone. If done or a withdrawal coincides with the limit, timeout stays 0.
  - GAP: one mandatory idle cycle (break-before-make; dout=0). Next state=IDLE. No arbitration in GAP, so a new grant appears at the earliest 2 cycles after release.
- Max grant length is MAX_HOLD cycles of dout active. MAX_HOLD=1 gives 1-cycle grants.
- en low in BUSY or GAP has no effect on the current grant. en low in IDLE blocks new grants; req stays pending with no loss of fairness.
- done in IDLE or GAP is ignored.
- Requests on non-granted bits during BUSY are only considered at the next IDLE arbitration.
- Fairness: a continuously asserted requester is granted within 7 other grants.
- dout is always zero or one-hot; never more than one bit set.
- Reset asserted mid-grant: outputs clear asynchronously to reset values, ptr returns to 7.

Test Plan:
1. Reset, then req=8'h01, en=1 -> one cycle later gnt_vld=1, gnt_idx=0, dout=8'h01. Pulse done -> next cycle dout=8'h00 (GAP), then IDLE.
2. req=8'hFF held, done pulsed 1 cycle after each grant -> grant order 0,1,2,...,7,0. Each dout one-hot with one zero GAP cycle between grants.
3. MAX_HOLD=16, req=8'h08 held, done=0 -> dout=8'h08 for exactly 16 cycles, then timeout=1 for 1 cycle with dout=0, then re-grant of idx 3.
4. Last grant idx=5, then req=8'h21 -> next grant idx 0 (wrap past 6,7), then idx 5.
5. During BUSY on idx 2: drop req[2] -> release next edge, timeout=0. Separately, done asserted on the same edge as the hold limit -> timeout=0.
6. en=0 with req=8'h10 -> no grant for 10 cycles. Raise en -> grant idx 4 next cycle. Assert rst_n=0 mid-BUSY -> dout=0 immediately. After release, req=8'hFF -> first grant idx 0.
